// File: rtl/rr_arbiter8_pkg.sv
// Shared constants for the 8-way round-robin arbiter: requester count, index width,
// FSM encodings and the default grant hold limit.
package rr_arbiter8_pkg;

    localparam int unsigned N_REQ        = 8;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned HOLD_MAX_DEF = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // One-hot grant vector for a binary requester index.
    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// rr_pick8: combinational rotating first-set-bit search starting at ptr (mod 8).
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    assign any = |req;

    // Scan from the far end back toward ptr so the closest set bit wins last.
    always_comb begin
        idx = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ptr + IDX_W'(k)]) begin
                idx = ptr + IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: two-state round-robin arbiter for 8 requesters with registered grant.
// Optional forced-release timeout is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] sel,
    output logic             valid,
    output logic             timeout
);

    if (HOLD_MAX < 1) begin : g_hold_chk
        $error("rr_arbiter8: HOLD_MAX must be at least 1");
    end

    logic [0:0]       r_state;
    logic             r_armed;
    logic [IDX_W-1:0] r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_sel;
    logic             r_valid;

    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0] w_sel_nxt;
    logic             w_valid_nxt;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_nat_rel;
    logic             w_hold_hit;
    logic             w_release;

    rr_pick8 u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_nat_rel = done | ~req[r_sel];
    assign w_release = w_nat_rel | w_hold_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    assign w_hold_hit = (r_state == ST_GRANT) &&
                        ((r_hold_cnt + CNT_W'(1)) == CNT_W'(HOLD_MAX));

    // Counter sits at zero outside GRANT, so every new grant starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_hold_hit & ~w_nat_rel;
            if ((r_state == ST_GRANT) && !w_release) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_hold_hit = 1'b0;
    assign timeout    = 1'b0;
`endif

    // r_armed delays arbitration by one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                if (r_armed && w_pick_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = idx2onehot(w_pick_idx);
                    w_sel_nxt   = w_pick_idx;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_GRANT: begin
                // Releasing owner becomes lowest priority for the next round.
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_sel + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter HOLD_MAX, default 16, is the maximum cycles one grant is held; it is used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request per requester i (bit i), level-sensitive.
REQ-005 done  input  1  current owner's release strobe, sampled only in GRANT.
REQ-006 gnt  output  8  registered one-hot grant; all-zero when no owner.
REQ-007 sel  output  3  registered binary index of owner; drives the shared mux8to1 select.
REQ-008 valid  output  1  high while gnt is non-zero.
REQ-009 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 FSM SHALL have exactly two states: IDLE and GRANT.
REQ-011 IDLE, req==0: remain in IDLE; gnt=0; valid=0; sel holds its last value.
REQ-012 IDLE, req!=0: winner = first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
- Next edge: gnt=onehot(winner), sel=winner, valid=1, state=GRANT.
- Latency: one cycle from req sampled to grant visible.
REQ-013 GRANT: gnt, sel and valid SHALL stay constant while req[sel]=1 and done=0, regardless of other requests.
REQ-014 Release condition: done=1, or req[sel]=0, in GRANT.
- Next edge: gnt=0, valid=0, ptr=(sel+1) mod 8 (wraps 7 to 0), state=IDLE.
REQ-015 After every release, IDLE SHALL last exactly one cycle before any new grant; back-to-back grants are never issued.
REQ-016 Simultaneous done=1 and req[sel]=0 SHALL count as a single release.
REQ-017 A requester re-asserting req in the release cycle SHALL NOT be favoured; the ptr rotation decides.
REQ-018 gnt SHALL never have more than one bit set.
REQ-019 When valid=1, sel SHALL equal the index of the set gnt bit.

Reset
REQ-020 rst_n low SHALL immediately, without waiting for clk, force:
- state=IDLE, gnt=0, sel=0, valid=0, timeout=0, ptr=0, hold counter=0.
REQ-021 Reset asserted mid-grant SHALL drop the grant at once; after release, the first arbitration SHALL start from ptr=0.
REQ-022 Reset deassertion SHALL take effect at the next rising edge; no grant appears earlier than the second edge after deassertion.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: a hold counter SHALL
- clear on entry to GRANT;
- increment each GRANT cycle;
- on reaching HOLD_MAX, force a release per REQ-014 and pulse timeout=1 for one cycle, coincident with gnt going to 0.
REQ-024 Macro ARB_TIMEOUT_EN undefined:
- no counter is built;
- timeout SHALL be tied to 0;
- grants are held indefinitely until the release condition of REQ-014.

Structure
REQ-025 A shared package/header SHALL hold:
- requester count (8) and index width (3);
- state encodings IDLE=0, GRANT=1;
- the HOLD_MAX default.
REQ-026 The rotating first-set-bit search SHALL be a separate combinational sub-module, rr_pick8 (inputs: req[7:0], ptr[2:0]; outputs: idx[2:0], any).
REQ-027 rr_arbiter8 SHALL contain only the FSM, ptr, hold counter and output registers.

Verification
REQ-028 After reset, req=8'b0000_0001 -> one cycle later gnt=01, sel=0, valid=1.
REQ-029 Starting from ptr=0, all eight requests held with done pulsed every grant -> sel sequence 0,1,2,...,7,0, with one idle cycle between grants.
REQ-030 ptr=6, req=8'b0100_0001 -> grant to 6 first, then 0 (wrap); requester 7 is never granted.
REQ-031 Owner 3 active, req[3] held, done=0, req[5] raised -> gnt stays 08 for 10 cycles; after done, gnt goes to 0, then to 20 one cycle later.
REQ-032 rst_n pulsed low mid-grant between edges -> gnt=0 and valid=0 immediately; first grant after release goes to the lowest set req bit.
REQ-033 With ARB_TIMEOUT_EN, HOLD_MAX=4, req[2] held and done=0 -> gnt=04 for 4 cycles, then timeout pulse with gnt=0; without the macro, gnt=04 persists for 100 cycles and timeout stays 0.
